bin_to_bcd_seq: RTL and testbench

//  Sequential double-dabble converter. Turns the CPU output-register value into packed BCD digits.

---
 rtl/bin_to_bcd_seq_pkg.sv | 29 ++
 rtl/bin_to_bcd_seq_add3.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 95 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types for the binary-to-BCD converter and the seven-segment driver it feeds.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Segment pattern {g,f,e,d,c,b,a}, active high; the driver decodes one BCD digit at a time.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one shift per clock, with a one-deep pending request slot.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);

  if (10**DIGITS <= 2**WIDTH) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small to hold every WIDTH-bit value");
  end

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    shift_reg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] scratch_adj;
  logic [WIDTH-1:0]    pending;
  logic                pending_valid;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  // A load seen in COMMIT is started straight away on the COMMIT->SHIFT edge; it beats an
  // older pending value because the newest request wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      shift_reg     <= '0;
      scratch       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      bcd           <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shift_reg <= value;
            scratch   <= '0;
            cnt       <= CW'(WIDTH);
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_COMMIT;
          if (load) begin
            pending       <= value;
            pending_valid <= 1'b1;
          end
        end
        ST_COMMIT: begin
          bcd  <= scratch;
          done <= 1'b1;
          if (load || pending_valid) begin
            shift_reg     <= load ? value : pending;
            scratch       <= '0;
            cnt           <= CW'(WIDTH);
            pending_valid <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: table vectors, hand-written timing corners and an exhaustive sweep,
// all checked against a scoreboard filled from a reference divide-by-ten model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  value = '0;
  logic [11:0] bcd;
  logic        done;
  logic        busy;

  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;
  int          loadCycle = 0;
  int          lastDoneCycle = -1;
  int          doneCount = 0;
  logic [11:0] lastBcd = '0;
  logic [11:0] expQ[$];

  typedef struct {
    int          val;
    logic [11:0] exp;
  } vector_t;

  vector_t vecs[5];

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .bcd   (bcd),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic logic [11:0] refBcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Scoreboard pop on every done; between dones bcd must not move.
  always @(negedge clk) begin
    if (rst) begin
      lastBcd = '0;
    end else if (done) begin
      doneCount++;
      lastDoneCycle = cycle;
      if (expQ.size() == 0) checkOutput("unexpected done", int'(done), 0);
      else checkOutput("scoreboard bcd", int'(bcd), int'(expQ.pop_front()));
      lastBcd = bcd;
    end else begin
      checkOutput("bcd hold", int'(bcd), int'(lastBcd));
    end
  end

  // Called just after a rising edge; drives a one-cycle load and models the pending overwrite.
  task automatic applyStimulus(input int v, input bit dropsPending);
    value = 8'(v);
    load  = 1'b1;
    if (dropsPending && expQ.size() > 0) void'(expQ.pop_back());
    expQ.push_back(refBcd(v));
    loadCycle = cycle;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    bit ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (expQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) checkOutput({name, " timeout"}, expQ.size(), 0);
  endtask

  initial begin
    int firstLoad;
    int base;

    vecs[0] = '{0,   12'h000};
    vecs[1] = '{99,  12'h099};
    vecs[2] = '{128, 12'h128};
    vecs[3] = '{9,   12'h009};
    vecs[4] = '{200, 12'h200};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset bcd", int'(bcd), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset busy", int'(busy), 0);

    $display("[TB] basic 255");
    applyStimulus(255, 1'b0);
    waitIdle("basic", 20);
    checkOutput("basic latency", lastDoneCycle - loadCycle, 10);
    checkOutput("basic bcd", int'(bcd), 12'h255);
    @(negedge clk);
    #1;
    checkOutput("basic busy after done", int'(busy), 0);
    checkOutput("basic done width", int'(done), 0);
    idle(1);

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].val, 1'b0);
      waitIdle("table", 20);
      checkOutput("table latency", lastDoneCycle - loadCycle, 10);
      checkOutput("table bcd", int'(bcd), int'(vecs[i].exp));
      idle(2);
    end

    $display("[TB] overwrite pending");
    base = doneCount;
    applyStimulus(12, 1'b0);
    idle(2);
    applyStimulus(200, 1'b0);
    idle(1);
    applyStimulus(7, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (doneCount - base >= 2) break;
      checkOutput("overwrite busy", int'(busy), 1);
    end
    checkOutput("overwrite done count", doneCount - base, 2);
    checkOutput("overwrite final bcd", int'(bcd), 12'h007);
    idle(2);

    $display("[TB] load in COMMIT cycle");
    base = doneCount;
    applyStimulus(45, 1'b0);
    firstLoad = loadCycle;
    idle(8);
    applyStimulus(46, 1'b0);
    waitIdle("commit", 30);
    checkOutput("commit done count", doneCount - base, 2);
    checkOutput("commit second latency", lastDoneCycle - firstLoad, 19);
    checkOutput("commit bcd", int'(bcd), 12'h046);
    idle(2);

    $display("[TB] reset mid-conversion");
    applyStimulus(200, 1'b0);
    idle(3);
    rst = 1'b1;
    expQ.delete();
    idle(1);
    rst = 1'b0;
    checkOutput("midreset bcd", int'(bcd), 0);
    checkOutput("midreset busy", int'(busy), 0);
    base = doneCount;
    idle(12);
    checkOutput("midreset no done", doneCount - base, 0);
    applyStimulus(33, 1'b0);
    waitIdle("after reset", 20);
    checkOutput("after reset latency", lastDoneCycle - loadCycle, 10);
    checkOutput("after reset bcd", int'(bcd), 12'h033);
    idle(1);

    $display("[TB] exhaustive sweep");
    for (int v = 0; v < 256; v++) begin
      applyStimulus(v, 1'b0);
      waitIdle("sweep", 20);
      idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
